mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDRESS_BITS, default 16, giving the memory word-address width.
REQ-002 The module SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive cycles the fetch port may be denied.
REQ-003 The module SHALL have these ports, one per line: name, direction, width, meaning:
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- i_req  input  1  fetch request
- i_addr  input  ADDRESS_BITS  fetch address
- i_gnt  output  1  fetch request accepted this cycle
- i_rvalid  output  1  fetch read data valid
- i_rdata  output  32  fetch read data
- d_req  input  1  data request
- d_wen  input  1  1 = store, 0 = load
- d_addr  input  ADDRESS_BITS  data address
- d_wdata  input  32  store data
- d_gnt  output  1  data request accepted this cycle
- d_rvalid  output  1  load data valid
- d_rdata  output  32  load data
- m_en  output  1  memory access enable
- m_wen  output  1  memory write enable
- m_addr  output  ADDRESS_BITS  memory address
- m_wdata  output  32  memory write data
- m_rdata  input  32  memory read data, valid the cycle after a read with m_en=1

Function
REQ-004 Arbitration SHALL be combinational in the request cycle; at most one of i_gnt, d_gnt SHALL be 1 in any cycle.
REQ-005 Default priority SHALL be data over fetch: d_req=1 gives d_gnt=1 regardless of i_req.
REQ-006 When only i_req=1, i_gnt SHALL be 1 in the same cycle.
REQ-007 When a grant is made, m_en SHALL be 1 and m_addr, m_wen, m_wdata SHALL come from the granted port; a fetch grant SHALL drive m_wen=0 and m_wdata=0.
REQ-008 With no grant, m_en and m_wen SHALL be 0; m_addr and m_wdata SHALL be 0.
REQ-009 A granted read SHALL give exactly one rvalid pulse on its own port, one cycle after the grant, with rdata equal to m_rdata in that cycle.
REQ-010 A granted store SHALL give no rvalid pulse.
REQ-011 rvalid outputs SHALL be registered; rdata outputs SHALL be 0 when the matching rvalid is 0.
REQ-012 Back-to-back grants SHALL be allowed every cycle, on either port, with no bubble; a rvalid for grant N SHALL coincide with grant N+1.
REQ-013 Requesters SHALL hold req, address, wen and wdata stable until gnt; the arbiter SHALL not buffer requests.
REQ-014 An in-flight tracker SHALL hold one of three states: IDLE (no read in flight), IRD (fetch read in flight), DRD (load in flight); next state is set by the current cycle's grant: fetch grant -> IRD, load grant -> DRD, store grant or no grant -> IDLE.

Reset
REQ-015 When reset=1 at a rising edge, the tracker SHALL go to IDLE, the starvation counter SHALL go to 0, and i_rvalid and d_rvalid SHALL be 0 in the next cycle.
REQ-016 While reset=1, i_gnt, d_gnt, m_en and m_wen SHALL be 0 regardless of requests.
REQ-017 A read granted in the cycle before reset rises SHALL produce no rvalid pulse.

Configuration
REQ-018 When macro MEM_ARB_FAIRNESS_EN is defined, a counter of width $clog2(STARVE_LIMIT+1) SHALL count cycles in which i_req=1 and i_gnt=0; the counter SHALL clear on i_gnt or when i_req=0.
REQ-019 When MEM_ARB_FAIRNESS_EN is defined and the counter equals STARVE_LIMIT, the fetch port SHALL win over d_req in that cycle.
REQ-020 When MEM_ARB_FAIRNESS_EN is not defined, no counter logic SHALL exist and REQ-005 strict priority SHALL always apply.

Verification
REQ-021 Scenario: i_req=1, i_addr=0x0010, d_req=0 -> same cycle i_gnt=1, m_addr=0x0010, m_en=1; next cycle i_rvalid=1, i_rdata=m_rdata.
REQ-022 Scenario: i_req=1 and d_req=1 (load, d_addr=0x0200) together, no fairness -> d_gnt=1, i_gnt=0; next cycle d_rvalid=1, i_rvalid=0.
REQ-023 Scenario: d_req=1, d_wen=1, d_addr=0x0300, d_wdata=0xDEADBEEF -> m_wen=1, m_wdata=0xDEADBEEF, and d_rvalid=0 on the next cycle.
REQ-024 Scenario: alternating fetch and load grants on 6 consecutive cycles -> 6 rvalid pulses, each on the correct port, with no bubble.
REQ-025 Scenario: with MEM_ARB_FAIRNESS_EN and STARVE_LIMIT=4, i_req=1 and d_req=1 held constant -> d_gnt for 4 cycles, i_gnt on the 5th cycle, then the pattern repeats.
REQ-026 Scenario: fetch grant in cycle N, reset=1 in cycle N+1 -> i_rvalid=0 in cycle N+1 and N+2; all grants 0 while reset=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// single-cycle-latency memory. Data requests win by default; the arbiter does
// not buffer requests, and read data returns on the requesting port one cycle
// after the grant.
// Optional build macro: MEM_ARB_FAIRNESS_EN adds a starvation counter that
// forces a fetch grant after STARVE_LIMIT consecutive denied fetch cycles.
module mem_arbiter #(
   parameter int ADDRESS_BITS = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_req,
   input  logic [ADDRESS_BITS-1:0] i_addr,
   output logic                    i_gnt,
   output logic                    i_rvalid,
   output logic [31:0]             i_rdata,
   input  logic                    d_req,
   input  logic                    d_wen,
   input  logic [ADDRESS_BITS-1:0] d_addr,
   input  logic [31:0]             d_wdata,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [31:0]             d_rdata,
   output logic                    m_en,
   output logic                    m_wen,
   output logic [ADDRESS_BITS-1:0] m_addr,
   output logic [31:0]             m_wdata,
   input  logic [31:0]             m_rdata
);

   // In-flight tracker encoding: which port (if any) owns the read that
   // the memory is returning this cycle.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_IRD  = 2'd1;
   localparam logic [1:0] ST_DRD  = 2'd2;

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       i_win;
   logic       d_win;
   logic       fetch_boost;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_q;
   logic [CW-1:0] starve_d;

   // Fetch is forced through once it has been denied STARVE_LIMIT cycles in a row.
   assign fetch_boost = (starve_q == STARVE_MAX);

   // Count consecutive cycles where fetch asks but is refused; any fetch
   // grant or a dropped request starts the count again.
   always_comb begin
      starve_d = starve_q;
      if (!i_req || i_win) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clock) begin
      if (reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign fetch_boost = 1'b0;
`endif

   // Grant decision for the current cycle; nothing is granted while in reset.
   always_comb begin
      i_win = 1'b0;
      d_win = 1'b0;
      if (!reset) begin
         if (i_req && fetch_boost) begin
            i_win = 1'b1;
         end else if (d_req) begin
            d_win = 1'b1;
         end else if (i_req) begin
            i_win = 1'b1;
         end
      end
   end

   assign i_gnt = i_win;
   assign d_gnt = d_win;

   // Steer the granted port onto the memory bus; idle bus is driven to zero.
   always_comb begin
      m_en    = 1'b0;
      m_wen   = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (d_win) begin
         m_en    = 1'b1;
         m_wen   = d_wen;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end else if (i_win) begin
         m_en    = 1'b1;
         m_addr  = i_addr;
      end
   end

   // Record which port's read will return next cycle; stores and idle
   // cycles leave nothing in flight.
   always_comb begin
      state_d = ST_IDLE;
      if (i_win) begin
         state_d = ST_IRD;
      end else if (d_win && !d_wen) begin
         state_d = ST_DRD;
      end
   end

   // Tracker register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Return path: the registered tracker picks the port. Reset also masks
   // the pulse so a read granted just before reset never reports back.
   always_comb begin
      i_rvalid = (state_q == ST_IRD) && !reset;
      d_rvalid = (state_q == ST_DRD) && !reset;
      i_rdata  = i_rvalid ? m_rdata : 32'd0;
      d_rdata  = d_rvalid ? m_rdata : 32'd0;
   end

endmodule
